bcd_add_seq: RTL

Digit-serial sequencer for BCD addition. It accepts two packed BCD operands through a valid/ready handshake and reuses one single-digit BCD add stage once per digit, least-significant digit first. It returns the packed BCD sum and carry-out through a second valid/ready handshake. It sits between a control source (keypad/UART decode) and the display path, and replaces the fully parallel multi-digit BCD adder where area matters.

---
 rtl/bcd_add_seq_if.sv | 22 ++
 rtl/bcd_add_seq.sv | 90 +++++++++
 2 files changed

// File: rtl/bcd_add_seq_if.sv
// bcd_add_seq_if: request/result handshake bundle for the digit-serial BCD adder.
interface bcd_add_seq_if #(parameter int DIGITS = 3);
   logic                  start_valid;
   logic                  start_ready;
   logic [4*DIGITS-1:0]   a_bcd;
   logic [4*DIGITS-1:0]   b_bcd;
   logic                  cin;
   logic                  sum_valid;
   logic                  sum_ready;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  busy;
   logic                  err;
   modport master (
      output start_valid, a_bcd, b_bcd, cin, sum_ready,
      input  start_ready, sum_valid, sum, cout, busy, err
   );
   modport slave (
      input  start_valid, a_bcd, b_bcd, cin, sum_ready,
      output start_ready, sum_valid, sum, cout, busy, err
   );
endinterface

// File: rtl/bcd_add_seq.sv
// bcd_add_seq: digit-serial packed-BCD adder reusing one digit stage, LSD first.
// Define BCD_ERR_CHECK_EN to flag and skip operands holding nibbles above 9.
module bcd_add_seq #(
   parameter int DIGITS = 3
) (
   input logic          sys_clk,
   input logic          sys_rst_n,
   bcd_add_seq_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t          state, next;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_r, b_r, sum_r;
   logic            cout_r, rdy_r, vld_r, busy_r;
   logic [3:0]      a_d, b_d, s_d;
   logic [4:0]      t;
   logic            c_d, acc, last, bad;
   assign acc  = bus.start_valid && rdy_r;
   assign last = idx == IW'(DIGITS - 1);
   assign a_d  = a_r[4*idx +: 4];
   assign b_d  = b_r[4*idx +: 4];
   assign t    = {1'b0, a_d} + {1'b0, b_d} + {4'd0, carry};
   assign c_d  = t > 5'd9;
   assign s_d  = c_d ? 4'(t + 5'd6) : t[3:0];
`ifdef BCD_ERR_CHECK_EN
   logic err_r;
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         bad = bad | (bus.a_bcd[4*i +: 4] > 4'd9) | (bus.b_bcd[4*i +: 4] > 4'd9);
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) err_r <= 1'b0;
      else if (acc)   err_r <= bad;
   assign bus.err = err_r;
`else
   assign bad     = 1'b0;
   assign bus.err = 1'b0;
`endif
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) state <= IDLE;
      else            state <= next;
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = acc ? (bad ? DONE : ADD) : IDLE;
         ADD:     next = last ? DONE : ADD;
         DONE:    next = bus.sum_ready ? IDLE : DONE;
         default: next = IDLE;
      endcase
   end
   // Handshake flags are registered from next state so start_ready stays low during reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         rdy_r  <= 1'b0;
         vld_r  <= 1'b0;
         busy_r <= 1'b0;
         idx    <= '0;
         carry  <= 1'b0;
         a_r    <= '0;
         b_r    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         rdy_r  <= next == IDLE;
         vld_r  <= next == DONE;
         busy_r <= next != IDLE;
         if (acc) begin
            a_r    <= bus.a_bcd;
            b_r    <= bus.b_bcd;
            carry  <= bus.cin;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
         end else if (state == ADD) begin
            sum_r[4*idx +: 4] <= s_d;
            carry             <= c_d;
            if (last) cout_r <= c_d;
            else      idx    <= idx + 1'b1;
         end
      end
   assign bus.start_ready = rdy_r;
   assign bus.sum_valid   = vld_r;
   assign bus.busy        = busy_r;
   assign bus.sum         = sum_r;
   assign bus.cout        = cout_r;
endmodule
